// File: rtl/multi_mode_alu_pkg.sv
// Shared definitions for the multi-mode ALU family.
// The forward ALU and its inverse both use these constants.
// Contents:
//   - default operand width A_W and result width Y_W
//   - mode encodings
//   - FSM state encoding for the inverse ALU
package multi_mode_alu_pkg;

    localparam int A_W = 4;
    localparam int Y_W = 2 * A_W;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_MUL  = 2'b01;
    localparam logic [1:0] MODE_SHR2 = 2'b10;
    localparam logic [1:0] MODE_ONES = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_div_restoring.sv
// Restoring divider: one quotient bit per clock, MSB first.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             load dividend/divisor; iterations start on the next edge
//   dividend/divisor  operands, sampled only when start is high
//   busy              iterations in progress
//   done              high in the cycle whose edge performs the final iteration
//   quotient          quotient after the current iteration (final when done=1)
//   remainder         remainder after the current iteration (final when done=1)
// quotient/remainder are the next-state values of the working registers, so a
// consumer that registers them while done=1 captures the result on the same
// edge as the last iteration. The divisor must be non-zero.
module seq_div_restoring #(
    parameter int DVD_W = 8,
    parameter int DVS_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DVD_W);

    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Partial remainder stays below the divisor, so one extra bit is enough
    // for the shifted trial value; the MSB of the difference is the borrow.
    logic [DVS_W:0]   trial;
    logic [DVS_W:0]   diff;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        trial  = {rem_q, quo_q[DVD_W-1]};
        diff   = trial - {1'b0, dvs_q};
        done   = busy_q && (cnt_q == CNT_W'(DVD_W - 1));

        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Dividend bits shift out of the top of quo as quotient bits shift in.
            if (!diff[DVS_W]) begin
                rem_d = diff[DVS_W-1:0];
                quo_d = {quo_q[DVD_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DVS_W-1:0];
                quo_d = {quo_q[DVD_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign quotient  = quo_d;
    assign remainder = rem_d;

endmodule

// File: rtl/multi_mode_inverse_alu.sv
// Inverse of the 4-bit multi-mode ALU: given result Y, operand B and Mode,
// recover operand A (plus a remainder for multiply), or flag that no A_W-bit
// A exists.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   Y, B, Mode            forward result, operand B, forward mode
//   out_valid / out_ready result handshake; result held until consumed
//   A, rem, err           recovered operand, remainder (multiply only), error
// Flow: IDLE accepts and captures the request. CALC produces the result one
// edge later, except non-zero-divisor multiply, which waits for the divider.
// DONE holds the registered result until out_ready.
module multi_mode_inverse_alu #(
    parameter int A_W = multi_mode_alu_pkg::A_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*A_W-1:0]     Y,
    input  logic [A_W-1:0]       B,
    input  logic [1:0]           Mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W-1:0]       A,
    output logic [A_W-1:0]       rem,
    output logic                 err
);

    import multi_mode_alu_pkg::*;

    localparam int Y_W = 2 * A_W;

    state_t         state_q, state_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [A_W-1:0] b_q, b_d;
    logic [1:0]     mode_q, mode_d;
    logic [A_W-1:0] a_q, a_d;
    logic [A_W-1:0] rem_q, rem_d;
    logic           err_q, err_d;
    logic           out_valid_q, out_valid_d;

    logic           div_start;
    logic           div_busy;
    logic           div_done;
    logic [Y_W-1:0] div_quo;
    logic [A_W-1:0] div_rem;

    // Single-edge result for every case except a real divide.
    logic [Y_W-1:0] sub_w;
    logic [A_W-1:0] imm_a;
    logic           imm_err;
    logic           use_div;

    seq_div_restoring #(
        .DVD_W (Y_W),
        .DVS_W (A_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (Y),
        .divisor   (B),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        sub_w   = y_q - Y_W'(b_q);
        imm_a   = '0;
        imm_err = 1'b0;
        case (mode_q)
            MODE_ADD: begin
                // On error A is still the wrapped difference, truncated.
                imm_a   = sub_w[A_W-1:0];
                imm_err = (y_q < Y_W'(b_q)) || (|sub_w[Y_W-1:A_W]);
            end
            MODE_MUL: begin
                // Only reached for a zero divisor.
                imm_a   = '0;
                imm_err = 1'b1;
            end
            MODE_SHR2: begin
                // Smallest A whose >>2 gives Y; Y must fit in A_W-2 bits.
                imm_a   = {y_q[A_W-3:0], 2'b00};
                imm_err = |y_q[Y_W-1:A_W-2];
            end
            default: begin
                imm_a   = '0;
                imm_err = (y_q != '1);
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        b_d         = b_q;
        mode_d      = mode_q;
        a_d         = a_q;
        rem_d       = rem_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        div_start   = 1'b0;
        use_div     = (mode_q == MODE_MUL) && (b_q != '0);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    y_d       = Y;
                    b_d       = B;
                    mode_d    = Mode;
                    state_d   = ST_CALC;
                    // The divider loads its own copy of the operands here.
                    div_start = (Mode == MODE_MUL) && (B != '0);
                end
            end
            ST_CALC: begin
                if (use_div) begin
                    if (div_done) begin
                        a_d         = div_quo[A_W-1:0];
                        rem_d       = div_rem;
                        err_d       = |div_quo[Y_W-1:A_W];
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (!div_busy) begin
                        // Divider idle without finishing: report an error
                        // rather than stall forever.
                        a_d         = '0;
                        rem_d       = '0;
                        err_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end else begin
                    a_d         = imm_a;
                    rem_d       = '0;
                    err_d       = imm_err;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            y_q         <= '0;
            b_q         <= '0;
            mode_q      <= MODE_ADD;
            a_q         <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            a_q         <= a_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign A         = a_q;
    assign rem       = rem_q;
    assign err       = err_q;

endmodule

// File: tb/tb_multi_mode_inverse_alu.sv
// Directed bench for multi_mode_inverse_alu: inputs driven and outputs
// sampled 1 time unit after the rising edge; expected values hand-computed.
module tb_multi_mode_inverse_alu;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] Y;
    logic [3:0] B;
    logic [1:0] Mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] A;
    logic [3:0] rem;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    multi_mode_inverse_alu #(.A_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .B         (B),
        .Mode      (Mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .rem       (rem),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one edge; it must be accepted on that edge.
    task automatic send(input logic [7:0] y, input logic [3:0] b, input logic [1:0] m);
        Y        = y;
        B        = b;
        Mode     = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("accept_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic check_res(input string tag, input logic [3:0] a, input logic [3:0] r, input logic e);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_A"},     32'(A),         32'(a));
        check({tag, "_rem"},   32'(rem),       32'(r));
        check({tag, "_err"},   32'(err),       32'(e));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consume_out_valid", 32'(out_valid), 32'd0);
        check("consume_in_ready",  32'(in_ready),  32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Y         = '0;
        B         = '0;
        Mode      = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_A",         32'(A),         32'd0);
        check("rst_rem",       32'(rem),       32'd0);
        check("rst_err",       32'(err),       32'd0);
        rst = 1'b0;
        tick();

        // Inverse add
        send(8'd13, 4'd5, 2'b00);
        check("add_not_early", 32'(out_valid), 32'd0);
        tick();
        check_res("add_13_5", 4'd8, 4'd0, 1'b0);
        consume();

        send(8'd3, 4'd5, 2'b00);
        tick();
        check_res("add_neg", 4'hE, 4'd0, 1'b1);
        consume();

        send(8'd30, 4'd5, 2'b00);
        tick();
        check_res("add_ovf", 4'd9, 4'd0, 1'b1);
        consume();

        // Inverse multiply: result exactly 8 edges after accept
        send(8'd42, 4'd6, 2'b01);
        repeat (7) tick();
        check("mul_not_early", 32'(out_valid), 32'd0);
        tick();
        check_res("mul_42_6", 4'd7, 4'd0, 1'b0);
        consume();

        send(8'd100, 4'd3, 2'b01);
        repeat (8) tick();
        check_res("mul_100_3", 4'h1, 4'd1, 1'b1);
        consume();

        // Divide by zero: one-edge latency
        send(8'h55, 4'd0, 2'b01);
        tick();
        check_res("mul_div0", 4'd0, 4'd0, 1'b1);
        consume();

        // Inverse shift-right-2
        send(8'h03, 4'd0, 2'b10);
        tick();
        check_res("shr_03", 4'hC, 4'd0, 1'b0);
        consume();

        send(8'h04, 4'd0, 2'b10);
        tick();
        check_res("shr_04", 4'h0, 4'd0, 1'b1);
        consume();

        // All-ones
        send(8'hFF, 4'd7, 2'b11);
        tick();
        check_res("ones_ff", 4'd0, 4'd0, 1'b0);
        consume();

        send(8'hFE, 4'd7, 2'b11);
        tick();
        check_res("ones_fe", 4'd0, 4'd0, 1'b1);
        consume();

        // Backpressure, with inputs scrambled while the divide runs
        send(8'd42, 4'd6, 2'b01);
        Y    = 8'h00;
        B    = 4'h0;
        Mode = 2'b11;
        in_valid = 1'b1;
        repeat (3) tick();
        Y = 8'hA5;
        B = 4'h9;
        repeat (4) tick();
        check("bp_not_early", 32'(out_valid), 32'd0);
        tick();
        check_res("bp_mul", 4'd7, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_res("bp_hold", 4'd7, 4'd0, 1'b0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        // in_valid is still high: a same-edge accept would drop in_ready.
        consume();
        in_valid = 1'b0;

        // Asynchronous reset in the middle of a divide
        send(8'hC8, 4'd7, 2'b01);
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_A",         32'(A),         32'd0);
        check("arst_rem",       32'(rem),       32'd0);
        check("arst_err",       32'(err),       32'd0);
        check("arst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;

        send(8'd9, 4'd4, 2'b00);
        tick();
        check_res("post_rst_add", 4'd5, 4'd0, 1'b0);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
